// File: rtl/uart_baud_gen.sv
// UART bit-rate timing generator: runs one frame of bit strobes and oversample
// ticks per bps_start request, with TX (end-of-bit) or RX (mid-bit) strobe phase.
module uart_baud_gen #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned FRAME_BITS = 10,
    parameter int unsigned OS_RATE    = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bps_start,
    input  logic [2:0] baud_sel,
    input  logic       mode,
    output logic       clk_bps,
    output logic       os_tick,
    output logic [3:0] bit_idx,
    output logic       busy,
    output logic       frame_done
);

    function automatic int unsigned baud_rate(input int unsigned idx);
        case (idx)
            0:       return 1200;
            1:       return 2400;
            2:       return 4800;
            3:       return 9600;
            4:       return 19200;
            5:       return 38400;
            6:       return 57600;
            default: return 115200;
        endcase
    endfunction

    function automatic int unsigned div_of(input int unsigned idx);
        return CLK_FREQ / baud_rate(idx);
    endfunction

    function automatic int unsigned max_div();
        int unsigned m;
        m = 0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (div_of(i) > m) m = div_of(i);
        end
        return m;
    endfunction

    function automatic int unsigned min_osdiv();
        int unsigned m;
        m = 32'hFFFF_FFFF;
        if (OS_RATE == 0) return 0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (div_of(i) / OS_RATE < m) m = div_of(i) / OS_RATE;
        end
        return m;
    endfunction

    localparam int unsigned MAX_DIV   = max_div();
    localparam int unsigned MIN_OSDIV = min_osdiv();
    localparam logic [3:0]  LAST_BIT  = 4'(FRAME_BITS - 1);

    if (MAX_DIV == 0 || ((MAX_DIV - 1) >> CNT_W) != 0) begin : g_bad_cnt_w
        $error("uart_baud_gen: largest divisor does not fit CNT_W");
    end
    if (MIN_OSDIV < 2) begin : g_bad_osdiv
        $error("uart_baud_gen: oversample divisor below 2");
    end
    if (FRAME_BITS > 15) begin : g_bad_frame
        $error("uart_baud_gen: FRAME_BITS above 15");
    end
    if (OS_RATE < 2) begin : g_bad_os_rate
        $error("uart_baud_gen: OS_RATE below 2");
    end

    // Constant divisor tables indexed by baud_sel; stored minus one where used as a wrap point.
    logic [CNT_W-1:0] div_m1_tab   [8];
    logic [CNT_W-1:0] half_tab     [8];
    logic [CNT_W-1:0] osdiv_m1_tab [8];

    for (genvar i = 0; i < 8; i++) begin : g_tab
        assign div_m1_tab[i]   = CNT_W'(div_of(i) - 1);
        assign half_tab[i]     = CNT_W'(div_of(i) / 2);
        assign osdiv_m1_tab[i] = CNT_W'(div_of(i) / OS_RATE - 1);
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0] div_m1_q, half_q, osdiv_m1_q;
    logic             mode_q;
    logic [CNT_W-1:0] cnt, os_cnt;
    logic [CNT_W-1:0] tap;
    logic             start, run_go, cnt_wrap, os_wrap, frame_end;

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        run_go    = 1'b0;
        tap       = mode_q ? half_q : div_m1_q;
        cnt_wrap  = (cnt == div_m1_q);
        os_wrap   = (os_cnt == osdiv_m1_q);
        frame_end = cnt_wrap && (bit_idx == LAST_BIT);
        case (state)
            IDLE: begin
                if (bps_start) begin
                    start     = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!bps_start) begin
                    state_nxt = IDLE;
                end else begin
                    run_go = 1'b1;
                    if (frame_end) state_nxt = DONE;
                end
            end
            DONE: begin
                if (!bps_start) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Strobes are only produced by a running frame that was not aborted on this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_m1_q   <= '0;
            half_q     <= '0;
            osdiv_m1_q <= '0;
            mode_q     <= 1'b0;
            cnt        <= '0;
            os_cnt     <= '0;
            bit_idx    <= '0;
            busy       <= 1'b0;
            clk_bps    <= 1'b0;
            os_tick    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            clk_bps    <= run_go && (cnt == tap);
            os_tick    <= run_go && os_wrap;
            frame_done <= run_go && frame_end;
            busy       <= (state_nxt == RUN);
            if (start) begin
                div_m1_q   <= div_m1_tab[baud_sel];
                half_q     <= half_tab[baud_sel];
                osdiv_m1_q <= osdiv_m1_tab[baud_sel];
                mode_q     <= mode;
                cnt        <= '0;
                os_cnt     <= '0;
                bit_idx    <= '0;
            end else if (run_go) begin
                if (cnt_wrap) begin
                    cnt     <= '0;
                    os_cnt  <= '0;
                    bit_idx <= frame_end ? 4'd0 : 4'(bit_idx + 4'd1);
                end else begin
                    cnt    <= cnt + 1'b1;
                    os_cnt <= os_wrap ? '0 : os_cnt + 1'b1;
                end
            end else begin
                cnt     <= '0;
                os_cnt  <= '0;
                bit_idx <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen at 50 MHz, 10-bit frames, 16x oversampling: a per-cycle
// arithmetic reference model plus directed timing sequences and a vector table.
module tb_uart_baud_gen;

    localparam int CLK_FREQ = 50000000;
    localparam int FRAME    = 10;
    localparam int OSR      = 16;

    logic       clk;
    logic       rst_n;
    logic       bps_start;
    logic [2:0] baud_sel;
    logic       mode;
    logic       clk_bps;
    logic       os_tick;
    logic [3:0] bit_idx;
    logic       busy;
    logic       frame_done;

    uart_baud_gen #(
        .CLK_FREQ  (CLK_FREQ),
        .FRAME_BITS(FRAME),
        .OS_RATE   (OSR),
        .CNT_W     (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bps_start (bps_start),
        .baud_sel  (baud_sel),
        .mode      (mode),
        .clk_bps   (clk_bps),
        .os_tick   (os_tick),
        .bit_idx   (bit_idx),
        .busy      (busy),
        .frame_done(frame_done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int e0    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // reference model: frame timing from elapsed cycles since the start edge
    int baud_tab [8] = '{1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200};
    bit         m_run  = 1'b0;
    bit         m_hold = 1'b0;
    bit         m_mode = 1'b0;
    int         m_t    = 0;
    int         m_div  = 1;
    int         m_half = 0;
    int         m_os   = 1;
    int         m_off  = 0;
    logic       e_bps  = 1'b0;
    logic       e_os   = 1'b0;
    logic       e_fd   = 1'b0;
    logic       e_busy = 1'b0;
    logic [3:0] e_bit  = 4'd0;

    always begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_run = 1'b0; m_hold = 1'b0;
            e_bps = 1'b0; e_os = 1'b0; e_fd = 1'b0; e_busy = 1'b0; e_bit = 4'd0;
        end else begin
            e_bps = 1'b0; e_os = 1'b0; e_fd = 1'b0;
            if (m_run) begin
                if (!bps_start) begin
                    m_run = 1'b0; e_busy = 1'b0; e_bit = 4'd0;
                end else begin
                    m_t   = m_t + 1;
                    m_off = m_t - ((m_t - 1) / m_div) * m_div;
                    e_bps = (m_off == (m_mode ? m_half + 1 : m_div));
                    e_os  = ((m_off % m_os) == 0);
                    if (m_t == FRAME * m_div) begin
                        m_run = 1'b0; m_hold = 1'b1;
                        e_fd = 1'b1; e_busy = 1'b0; e_bit = 4'd0;
                    end else begin
                        e_bit = 4'(m_t / m_div);
                    end
                end
            end else if (m_hold) begin
                if (!bps_start) m_hold = 1'b0;
            end else if (bps_start) begin
                m_run  = 1'b1;
                m_t    = 0;
                m_div  = CLK_FREQ / baud_tab[baud_sel];
                m_half = m_div / 2;
                m_os   = m_div / OSR;
                m_mode = mode;
                e_busy = 1'b1;
                e_bit  = 4'd0;
            end
        end
    end

    // scoreboard: per-cycle model compare and event-time capture
    logic [31:0] gq_bps[$];
    logic [31:0] gq_os[$];
    logic [31:0] gq_fd[$];
    logic [31:0] exp_q[$];

    always @(negedge clk) begin
        total++;
        if ({busy, bit_idx, clk_bps, os_tick, frame_done} !== {e_busy, e_bit, e_bps, e_os, e_fd}) begin
            bad++;
            $display("FAIL model_cycle cyc=%0d got busy=%b bit=%0d bps=%b os=%b fd=%b want busy=%b bit=%0d bps=%b os=%b fd=%b",
                     cyc, busy, bit_idx, clk_bps, os_tick, frame_done, e_busy, e_bit, e_bps, e_os, e_fd);
        end
        if (clk_bps)    gq_bps.push_back(32'(cyc));
        if (os_tick)    gq_os.push_back(32'(cyc));
        if (frame_done) gq_fd.push_back(32'(cyc));
    end

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic check_q(input string name, input int which);
        logic [31:0] g[$];
        case (which)
            0:       g = gq_bps;
            1:       g = gq_os;
            default: g = gq_fd;
        endcase
        check({name, "_count"}, g.size(), exp_q.size());
        for (int i = 0; i < g.size() && i < exp_q.size(); i++)
            check($sformatf("%s[%0d]", name, i), int'(g[i]), int'(exp_q[i]));
    endtask

    task automatic clear_q();
        gq_bps.delete(); gq_os.delete(); gq_fd.delete(); exp_q.delete();
    endtask

    // drivers
    task automatic start_frame(input logic [2:0] sel, input logic m);
        @(negedge clk);
        baud_sel  = sel;
        mode      = m;
        bps_start = 1'b1;
        @(posedge clk);
        #1 e0 = cyc;
    endtask

    task automatic stop_frame();
        @(negedge clk);
        bps_start = 1'b0;
    endtask

    task automatic measure_first(input int bound, output int t_bps, output int t_os);
        t_bps = -1;
        t_os  = -1;
        repeat (bound) begin
            @(negedge clk);
            if (clk_bps && t_bps < 0) t_bps = cyc - e0;
            if (os_tick && t_os < 0)  t_os  = cyc - e0;
        end
    endtask

    typedef struct {
        logic [2:0] sel;
        logic       m;
        int         exp_bps;
        int         exp_os;
    } vec_t;

    vec_t vecs [5];
    int   t_bps, t_os;

    initial begin
        vecs[0] = '{3'd7, 1'b1, 218, 27};
        vecs[1] = '{3'd6, 1'b0, 868, 54};
        vecs[2] = '{3'd6, 1'b1, 435, 54};
        vecs[3] = '{3'd5, 1'b1, 652, 81};
        vecs[4] = '{3'd7, 1'b0, 434, 27};

        rst_n = 1'b0; bps_start = 1'b0; baud_sel = 3'd0; mode = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({busy, bit_idx, clk_bps, os_tick, frame_done}), 0);
        #2 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_busy", int'(busy), 0);
        check("idle_strobes", gq_bps.size() + gq_os.size() + gq_fd.size(), 0);

        for (int i = 0; i < 5; i++) begin
            start_frame(vecs[i].sel, vecs[i].m);
            measure_first(vecs[i].exp_bps + 20, t_bps, t_os);
            check($sformatf("vec%0d_first_bps", i), t_bps, vecs[i].exp_bps);
            check($sformatf("vec%0d_first_os", i), t_os, vecs[i].exp_os);
            stop_frame();
        end

        // TX at 9600 with bps_start held high past the end of the frame
        start_frame(3'd3, 1'b0);
        clear_q();
        repeat (52080 + 40) @(posedge clk);
        @(negedge clk);
        for (int k = 1; k <= 10; k++) exp_q.push_back(32'(e0 + 5208 * k));
        check_q("tx3_bps", 0);
        exp_q.delete();
        exp_q.push_back(32'(e0 + 52080));
        check_q("tx3_done", 2);
        check("tx3_busy_after", int'(busy), 0);

        // re-arm with one low cycle
        stop_frame();
        start_frame(3'd3, 1'b0);
        measure_first(5230, t_bps, t_os);
        check("rearm_first_bps", t_bps, 5208);
        check("rearm_first_os", t_os, 325);
        stop_frame();

        // RX at 9600, aborted 3000 cycles into bit 4
        start_frame(3'd3, 1'b1);
        clear_q();
        repeat (23831) @(posedge clk);
        stop_frame();
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_bit_idx", int'(bit_idx), 0);
        repeat (20) @(negedge clk);
        for (int k = 0; k <= 4; k++) exp_q.push_back(32'(e0 + 2605 + 5208 * k));
        check_q("rx3_bps", 0);
        exp_q.delete();
        for (int b = 0; b <= 4; b++)
            for (int j = 1; j <= 16; j++)
                if (5208 * b + 325 * j <= 23831) exp_q.push_back(32'(e0 + 5208 * b + 325 * j));
        check_q("rx3_os", 1);
        exp_q.delete();
        check_q("rx3_no_done", 2);
        start_frame(3'd3, 1'b1);
        check("restart_bit_idx", int'(bit_idx), 0);
        check("restart_busy", int'(busy), 1);
        repeat (8) @(negedge clk);
        check("restart_bit_idx_hold", int'(bit_idx), 0);
        stop_frame();

        // 115200 with baud_sel/mode changed mid-frame
        start_frame(3'd7, 1'b0);
        clear_q();
        repeat (5 * 434 - 100) @(posedge clk);
        @(negedge clk);
        baud_sel = 3'd0;
        mode     = 1'b1;
        repeat (2300) @(posedge clk);
        @(negedge clk);
        for (int k = 1; k <= 10; k++) exp_q.push_back(32'(e0 + 434 * k));
        check_q("tx7_bps", 0);
        exp_q.delete();
        exp_q.push_back(32'(e0 + 4340));
        check_q("tx7_done", 2);
        check("tx7_busy_after", int'(busy), 0);

        // next frame picks up the 1200 bps setting
        stop_frame();
        start_frame(3'd0, 1'b1);
        measure_first(2700, t_bps, t_os);
        check("sel0_first_os", t_os, 2604);
        check("sel0_no_bps_yet", t_bps, -1);

        // asynchronous reset mid-frame, bps_start held high through it
        clear_q();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("reset_async", int'({busy, bit_idx, clk_bps, os_tick, frame_done}), 0);
        baud_sel = 3'd7;
        mode     = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 e0 = cyc;
        check("post_reset_busy", int'(busy), 1);
        check("post_reset_bit_idx", int'(bit_idx), 0);
        measure_first(450, t_bps, t_os);
        check("post_reset_first_bps", t_bps, 434);
        check("reset_no_done", gq_fd.size(), 0);
        stop_frame();

        // random short frames with settings toggled while running
        for (int r = 0; r < 3; r++) begin
            int len;
            len = int'($urandom_range(600, 100));
            start_frame(3'($urandom_range(7, 5)), 1'($urandom_range(1, 0)));
            repeat (len) begin
                @(negedge clk);
                baud_sel = 3'($urandom_range(7, 0));
                mode     = 1'($urandom_range(1, 0));
            end
            stop_frame();
            repeat (5) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
